// File: rtl/rvm_bitwise_ctrl_pkg.sv
// rvm_bitwise_ctrl_pkg: bitwise unit op codes, funct3 encodings and controller states
package rvm_bitwise_ctrl_pkg;
  localparam logic [2:0] RVM_BITWISE_NOP = 3'd0;
  localparam logic [2:0] RVM_BITWISE_OR  = 3'd1;
  localparam logic [2:0] RVM_BITWISE_AND = 3'd2;
  localparam logic [2:0] RVM_BITWISE_XOR = 3'd3;
  localparam logic [2:0] RVM_FUNCT3_OR   = 3'b110;
  localparam logic [2:0] RVM_FUNCT3_AND  = 3'b111;
  localparam logic [2:0] RVM_FUNCT3_XOR  = 3'b100;
  typedef enum logic [1:0] {
    RVM_BWC_IDLE = 2'd0,
    RVM_BWC_EXEC = 2'd1,
    RVM_BWC_HOLD = 2'd2
  } bwc_state_e;
endpackage

// File: rtl/rvm_bitwise_decode.sv
// rvm_bitwise_decode: funct3 to bitwise op code, flagging unsupported encodings
module rvm_bitwise_decode
  import rvm_bitwise_ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  output logic [2:0] op_o,
  output logic       illegal_o
);
  always_comb begin
    op_o = funct3_i == RVM_FUNCT3_OR  ? RVM_BITWISE_OR  :
           funct3_i == RVM_FUNCT3_AND ? RVM_BITWISE_AND :
           funct3_i == RVM_FUNCT3_XOR ? RVM_BITWISE_XOR : RVM_BITWISE_NOP;
    illegal_o = op_o == RVM_BITWISE_NOP;
  end
endmodule

// File: rtl/rvm_bitwise_ctrl.sv
// rvm_bitwise_ctrl: issues OR/AND/XOR requests to the bitwise unit and holds the result for writeback
module rvm_bitwise_ctrl
  import rvm_bitwise_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_lhs,
  input  logic [XLEN-1:0] req_rhs,
  input  logic [4:0]      req_rd,
  output logic [2:0]      fu_op,
  output logic [XLEN-1:0] fu_lhs,
  output logic [XLEN-1:0] fu_rhs,
  input  logic            fu_valid,
  input  logic [XLEN-1:0] fu_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_result,
  output logic            wb_error
);
  localparam int CW = $clog2(TIMEOUT + 1);
  bwc_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] lhs_q, lhs_d, rhs_q, rhs_d, res_q, res_d;
  logic [4:0]      rd_q, rd_d;
  logic            err_q, err_d;
  logic [2:0]      dec_op;
  logic            dec_ill;
  rvm_bitwise_decode u_decode (
    .funct3_i (req_funct3),
    .op_o     (dec_op),
    .illegal_o(dec_ill)
  );
  // Unit inputs are forced quiet outside EXEC so the unit never sees stale operands
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    lhs_d     = lhs_q;
    rhs_d     = rhs_q;
    res_d     = res_q;
    rd_d      = rd_q;
    err_d     = err_q;
    req_ready = state_q == RVM_BWC_IDLE && !flush;
    fu_op     = state_q == RVM_BWC_EXEC ? op_q : RVM_BITWISE_NOP;
    fu_lhs    = state_q == RVM_BWC_EXEC ? lhs_q : '0;
    fu_rhs    = state_q == RVM_BWC_EXEC ? rhs_q : '0;
    wb_valid  = state_q == RVM_BWC_HOLD;
    wb_rd     = wb_valid ? rd_q : '0;
    wb_result = wb_valid ? res_q : '0;
    wb_error  = wb_valid && err_q;
    wb_we     = wb_valid && !err_q && rd_q != '0;
    case (state_q)
      RVM_BWC_IDLE: if (req_valid && req_ready) begin
        op_d    = dec_op;
        lhs_d   = req_lhs;
        rhs_d   = req_rhs;
        rd_d    = req_rd;
        res_d   = '0;
        err_d   = dec_ill;
        state_d = dec_ill ? RVM_BWC_HOLD : RVM_BWC_EXEC;
      end
      RVM_BWC_EXEC: begin
        cnt_d = cnt_q == CW'(TIMEOUT) ? cnt_q : cnt_q + 1'b1;
        if (fu_valid) begin
          res_d   = fu_result;
          state_d = RVM_BWC_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RVM_BWC_HOLD;
          cnt_d   = '0;
        end
      end
      RVM_BWC_HOLD: if (wb_ready) begin
        state_d = RVM_BWC_IDLE;
        cnt_d   = '0;
      end
      default: state_d = RVM_BWC_IDLE;
    endcase
    if (flush) begin
      state_d = RVM_BWC_IDLE;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RVM_BWC_IDLE;
      cnt_q   <= '0;
      op_q    <= RVM_BITWISE_NOP;
      lhs_q   <= '0;
      rhs_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      lhs_q   <= lhs_d;
      rhs_q   <= rhs_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_rvm_bitwise_ctrl.sv
// tb_rvm_bitwise_ctrl: random and directed requests scored against a transaction-level model
module tb_rvm_bitwise_ctrl;
  import rvm_bitwise_ctrl_pkg::*;
  localparam int TO = 4;
  logic        clk = 0, reset = 1, flush = 0, req_valid = 0, wb_ready = 1;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_lhs = 0, req_rhs = 0;
  logic [4:0]  req_rd = 0;
  logic        req_ready, fu_valid, wb_valid, wb_we, wb_error;
  logic [2:0]  fu_op;
  logic [31:0] fu_lhs, fu_rhs, fu_result, wb_result;
  logic [4:0]  wb_rd;
  logic        stray = 0, rst_prev = 1, rnd = 0;
  int          fu_lat = 0, ecount = 0, cyc = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  rvm_bitwise_ctrl #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_lhs(req_lhs), .req_rhs(req_rhs), .req_rd(req_rd),
    .fu_op(fu_op), .fu_lhs(fu_lhs), .fu_rhs(fu_rhs),
    .fu_valid(fu_valid), .fu_result(fu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_result(wb_result), .wb_error(wb_error)
  );
  // Bitwise unit stand-in: answers after fu_lat EXEC cycles, noise on fu_valid elsewhere
  assign fu_valid = (fu_op != RVM_BITWISE_NOP) ? (ecount >= fu_lat) : stray;
  always_comb
    fu_result = fu_op == RVM_BITWISE_OR  ? (fu_lhs | fu_rhs) :
                fu_op == RVM_BITWISE_AND ? (fu_lhs & fu_rhs) :
                fu_op == RVM_BITWISE_XOR ? (fu_lhs ^ fu_rhs) : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    ecount   <= (fu_op != RVM_BITWISE_NOP) ? ecount + 1 : 0;
    rst_prev <= reset;
  end
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res, lhs, rhs;
    logic [2:0]  op;
    logic        err;
    int          wbc;
  } exp_t;
  exp_t q[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input int lat, input int now);
    exp_t e;
    logic ill = 1'b0;
    e.rd = rd; e.lhs = a; e.rhs = b;
    case (f3)
      3'b110:  begin e.op = RVM_BITWISE_OR;  e.res = a | b; end
      3'b111:  begin e.op = RVM_BITWISE_AND; e.res = a & b; end
      3'b100:  begin e.op = RVM_BITWISE_XOR; e.res = a ^ b; end
      default: begin e.op = RVM_BITWISE_NOP; e.res = 0; ill = 1'b1; e.lhs = 0; e.rhs = 0; end
    endcase
    e.err = ill || lat >= TO;
    if (e.err) e.res = 0;
    e.wbc = ill ? now + 1 : now + 2 + (lat >= TO ? TO - 1 : lat);
    return e;
  endfunction
  exp_t e;
  always @(negedge clk) begin
    if (rst_prev) begin
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_result", wb_result, 0);
      chk("rst_wb_error", wb_error, 0);
      chk("rst_wb_we", wb_we, 0);
    end
    if (q.size() == 0) begin
      chk("idle_wb_valid", wb_valid, 0);
      chk("idle_fu_op", fu_op, RVM_BITWISE_NOP);
      chk("idle_fu_lhs", fu_lhs, 0);
      chk("idle_fu_rhs", fu_rhs, 0);
      chk("idle_req_ready", req_ready, !flush);
      if (req_valid && req_ready && !reset)
        q.push_back(model(req_funct3, req_lhs, req_rhs, req_rd, fu_lat, cyc));
    end else begin
      e = q[0];
      chk("busy_req_ready", req_ready, 0);
      if (cyc < e.wbc) begin
        chk("exec_wb_valid", wb_valid, 0);
        chk("exec_fu_op", fu_op, e.op);
        chk("exec_fu_lhs", fu_lhs, e.lhs);
        chk("exec_fu_rhs", fu_rhs, e.rhs);
      end else begin
        chk("hold_wb_valid", wb_valid, 1);
        chk("hold_wb_rd", wb_rd, e.rd);
        chk("hold_wb_result", wb_result, e.res);
        chk("hold_wb_error", wb_error, e.err);
        chk("hold_wb_we", wb_we, !e.err && e.rd != 0);
        chk("hold_fu_op", fu_op, RVM_BITWISE_NOP);
        chk("hold_fu_lhs", fu_lhs, 0);
        if (wb_ready) void'(q.pop_front());
      end
    end
    if (reset || flush) q.delete();
  end
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bit ok = 0;
    req_funct3 = f3; req_lhs = a; req_rhs = b; req_rd = rd; req_valid = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL issue_timeout: got no req_ready expected accept"); end
    @(posedge clk); #1;
    req_valid = 0;
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wb_timeout: got pending writeback expected drained"); end
    @(posedge clk); #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end
  initial begin
    logic [2:0] legal [3] = '{3'b110, 3'b111, 3'b100};
    logic [2:0] f3;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    issue(3'b110, 32'hF0F0_0000, 32'h0000_0F0F, 5'd5); wait_idle();
    issue(3'b111, 32'hFFFF_00FF, 32'h0F0F_0F0F, 5'd7);
    issue(3'b100, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 5'd8); wait_idle();
    issue(3'b000, 32'h1234_5678, 32'h8765_4321, 5'd3); wait_idle();
    fu_lat = 100; issue(3'b110, 32'h1, 32'h2, 5'd9);  wait_idle();
    fu_lat = 2;   issue(3'b111, 32'hFF, 32'h0F, 5'd10); wait_idle();
    fu_lat = 3;   issue(3'b100, 32'h5, 32'h3, 5'd11);  wait_idle();
    fu_lat = 4;   issue(3'b110, 32'h5, 32'h3, 5'd12);  wait_idle();
    fu_lat = 0;   issue(3'b110, 32'hCAFE_0000, 32'h0000_BABE, 5'd0); wait_idle();
    wb_ready = 0;
    issue(3'b111, 32'h1357_9BDF, 32'hFFFF_0000, 5'd13);
    repeat (6) @(posedge clk);
    #1 wb_ready = 1;
    wait_idle();
    fu_lat = 100;
    issue(3'b110, 32'h1111_0000, 32'h0000_2222, 5'd14);
    flush = 1; req_valid = 1; req_funct3 = 3'b111;
    @(posedge clk); #1 flush = 0; req_valid = 0; fu_lat = 0;
    repeat (3) @(posedge clk); #1;
    req_funct3 = 3'b110; req_rd = 5'd15; req_valid = 1; flush = 1;
    @(posedge clk); #1 flush = 0; req_valid = 0;
    repeat (3) @(posedge clk); #1;
    wb_ready = 0;
    issue(3'b100, 32'h0F0F_0F0F, 32'h00FF_00FF, 5'd16);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0; wb_ready = 1;
    repeat (3) @(posedge clk); #1;
    rnd = 1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          fu_lat = $urandom_range(0, 5);
          f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : legal[$urandom_range(0, 2)];
          issue(f3, $urandom, $urandom, 5'($urandom));
          wait_idle();
        end
        rnd = 0;
      end
      begin
        while (rnd) begin
          @(posedge clk); #1;
          wb_ready = 1'($urandom);
          stray = 1'($urandom);
        end
      end
    join
    wb_ready = 1; stray = 0;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
